// File: rtl/mat_pkg.sv
// Shared types and defaults for the systolic matrix unit front end.
package mat_pkg;

  localparam int MAT_WIDTH  = 128;
  localparam int MAT_FPSIZE = 16;

  typedef logic [MAT_FPSIZE-1:0] fp_t;
  typedef fp_t [MAT_WIDTH-1:0]   vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } skew_state_e;

endpackage

// File: rtl/mat_skew_lane.sv
// One skew lane: a DEPTH-stage data + valid delay line that shifts only when enabled.
module mat_skew_lane #(
  parameter int DEPTH  = 1,
  parameter int FPSIZE = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_en,
  input  logic [FPSIZE-1:0] i_data,
  input  logic              i_valid,
  output logic [FPSIZE-1:0] o_data,
  output logic              o_valid
);

  logic [FPSIZE-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;

  // Shift the delay line one stage per advancing cycle; reset empties it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_vld <= '0;
    end else if (i_en) begin
      r_data[0] <= i_data;
      r_vld[0]  <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_vld[DEPTH-1];

endmodule

// File: rtl/mat_skew_feeder.sv
// Diagonal skew feeder for the systolic array row inputs.
// Lane k of each accepted vector is delayed k advancing cycles relative to lane 0.
// After the last vector of a burst, the feeder drains the skew and pulses done.
// Optional statistics counters are enabled by defining MAT_SKEW_STATS_EN.
module mat_skew_feeder
  import mat_pkg::*;
#(
  parameter int WIDTH  = MAT_WIDTH,
  parameter int FPSIZE = MAT_FPSIZE
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [WIDTH-1:0][FPSIZE-1:0] in_data,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0][FPSIZE-1:0] out_data,
  output logic [WIDTH-1:0]             out_lane_valid,
  output logic                         busy,
`ifdef MAT_SKEW_STATS_EN
  output logic [31:0]                  stat_vectors,
  output logic [31:0]                  stat_stall_cycles,
`endif
  output logic                         done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic                         w_adv;
  logic                         w_accept;
  logic [WIDTH-1:0][FPSIZE-1:0] w_st0_data;
  logic [WIDTH-1:0][FPSIZE-1:0] w_out_data;
  logic [WIDTH-1:0]             w_out_vld;

  skew_state_e      r_state;
  logic [CNT_W-1:0] r_drain_cnt;
  logic             r_done;

  // The whole feeder moves only when the consumer can take a wavefront.
  assign w_adv    = out_ready;
  assign in_ready = out_ready && (r_state != DRAIN);
  assign w_accept = in_valid && in_ready;

  // Non-accept cycles inject an all-zero, invalid column into every lane.
  always_comb begin
    w_st0_data = '0;
    if (w_accept) begin
      w_st0_data = in_data;
    end
  end

  // Lane k holds k+1 stages so the vector leaves as a diagonal wavefront.
  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    mat_skew_lane #(
      .DEPTH  (k + 1),
      .FPSIZE (FPSIZE)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .i_en    (w_adv),
      .i_data  (w_st0_data[k]),
      .i_valid (w_accept),
      .o_data  (w_out_data[k]),
      .o_valid (w_out_vld[k])
    );
  end

  // Burst FSM: track the open burst, then count the skew out before signalling done.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_adv) begin
        case (r_state)
          IDLE, STREAM: begin
            if (w_accept) begin
              if (in_last) begin
                r_state     <= DRAIN;
                r_drain_cnt <= CNT_W'(WIDTH - 1);
              end else begin
                r_state <= STREAM;
              end
            end
          end
          DRAIN: begin
            if (r_drain_cnt == '0) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt - 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out_data       = w_out_data;
  assign out_lane_valid = w_out_vld;
  assign out_valid      = |w_out_vld;
  assign busy           = (r_state != IDLE) || (|w_out_vld);
  assign done           = r_done;

`ifdef MAT_SKEW_STATS_EN
  logic [31:0] r_stat_vectors;
  logic [31:0] r_stat_stall;

  // Saturating counters of accepted vectors and stalled cycles with data pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_vectors <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_accept && (r_stat_vectors != '1)) begin
        r_stat_vectors <= r_stat_vectors + 32'd1;
      end
      if (out_valid && !out_ready && (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_vectors      = r_stat_vectors;
  assign stat_stall_cycles = r_stat_stall;
`endif

endmodule
